// File: rtl/conv2d_event_engine.sv
// Event-driven 2D convolution scatter engine: each accepted spike event walks the
// kernel footprint, accumulates BRAM weights per output channel and emits one beat per in-bounds target.
module conv2d_event_engine #(
    parameter int IN_CHANNELS  = 2,
    parameter int OUT_CHANNELS = 2,
    parameter int KERNEL_SIZE  = 3,
    parameter int WEIGHT_BITS  = 6,
    parameter int IMG_WIDTH    = 8,
    parameter int IMG_HEIGHT   = 8,
    parameter int COORD_BITS   = 8,
    parameter int SUM_BITS     = WEIGHT_BITS + $clog2(IN_CHANNELS) + 1,
    parameter int ADDR_BITS    = (KERNEL_SIZE * KERNEL_SIZE * IN_CHANNELS > 1) ?
                                 $clog2(KERNEL_SIZE * KERNEL_SIZE * IN_CHANNELS) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               ev_valid,
    output logic                               ev_ready,
    input  logic [COORD_BITS-1:0]              ev_x,
    input  logic [COORD_BITS-1:0]              ev_y,
    input  logic [IN_CHANNELS-1:0]             ev_spikes,
    output logic                               bram_en,
    output logic [ADDR_BITS-1:0]               bram_addr,
    input  logic [OUT_CHANNELS*WEIGHT_BITS-1:0] bram_rdata,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [COORD_BITS-1:0]              out_x,
    output logic [COORD_BITS-1:0]              out_y,
    output logic [OUT_CHANNELS*SUM_BITS-1:0]   out_sums,
    output logic                               out_last,
    output logic                               busy
);

    localparam int KB  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int CHB = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
    localparam int CW  = COORD_BITS + 2;
    localparam int AW  = OUT_CHANNELS * SUM_BITS;

    localparam logic signed [CW-1:0] R_S    = CW'(KERNEL_SIZE / 2);
    localparam logic signed [CW-1:0] KM1_S  = CW'(KERNEL_SIZE - 1);
    localparam logic signed [CW-1:0] XMAX_S = CW'(IMG_WIDTH - 1);
    localparam logic signed [CW-1:0] YMAX_S = CW'(IMG_HEIGHT - 1);
    localparam logic [KB-1:0]        KM1_K  = KB'(KERNEL_SIZE - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SCAN  = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_EMIT  = 3'd4;

    logic [2:0]             state_q, state_d;
    logic [COORD_BITS-1:0]  ex_q, ex_d, ey_q, ey_d;
    logic [IN_CHANNELS-1:0] sp_q, sp_d;
    logic [KB-1:0]          kx_q, kx_d, ky_q, ky_d;
    logic [CHB-1:0]         ch_q, ch_d;
    logic                   rvalid_q, rvalid_d;
    logic [AW-1:0]          acc_q, acc_d;
    logic                   ev_ready_q, ev_ready_d, busy_q, busy_d;
    logic                   bram_en_q, bram_en_d;
    logic [ADDR_BITS-1:0]   bram_addr_q, bram_addr_d;
    logic                   out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [COORD_BITS-1:0]  out_x_q, out_x_d, out_y_q, out_y_d;
    logic [AW-1:0]          out_sums_q, out_sums_d;

    logic signed [CW-1:0]   tx_s, ty_s, lim_x_s, lim_y_s, kxmax_s, kymax_s;
    logic                   inb_s, last_pos_s, final_pos_s;
    logic [KB-1:0]          kx_adv_s, ky_adv_s;
    logic [ADDR_BITS-1:0]   base_s;
    logic [AW-1:0]          acc_sum_s;
    logic [CHB:0]           first_s, next_s;

    // Lowest set channel at or above 'from'; MSB flags that one was found.
    function automatic logic [CHB:0] find_ch(input logic [IN_CHANNELS-1:0] mask, input int from);
        logic [CHB:0] r;
        r = '0;
        for (int i = IN_CHANNELS - 1; i >= 0; i--) begin
            if (mask[i] && (i >= from)) begin
                r = {1'b1, CHB'(i)};
            end
        end
        return r;
    endfunction

    function automatic logic [SUM_BITS-1:0] sext(input logic [WEIGHT_BITS-1:0] w);
        return {{(SUM_BITS - WEIGHT_BITS){w[WEIGHT_BITS-1]}}, w};
    endfunction

    // Target geometry; the in-bounds kernel region is a rectangle, so its max corner is the last beat.
    always_comb begin
        tx_s        = $signed({2'b00, ex_q}) + R_S - $signed({{(CW - KB){1'b0}}, kx_q});
        ty_s        = $signed({2'b00, ey_q}) + R_S - $signed({{(CW - KB){1'b0}}, ky_q});
        inb_s       = !tx_s[CW-1] && (tx_s <= XMAX_S) && !ty_s[CW-1] && (ty_s <= YMAX_S);
        lim_x_s     = $signed({2'b00, ex_q}) + R_S;
        lim_y_s     = $signed({2'b00, ey_q}) + R_S;
        kxmax_s     = (lim_x_s > KM1_S) ? KM1_S : lim_x_s;
        kymax_s     = (lim_y_s > KM1_S) ? KM1_S : lim_y_s;
        last_pos_s  = ($signed({{(CW - KB){1'b0}}, kx_q}) == kxmax_s) &&
                      ($signed({{(CW - KB){1'b0}}, ky_q}) == kymax_s);
        final_pos_s = (kx_q == KM1_K) && (ky_q == KM1_K);
        if (kx_q == KM1_K) begin
            kx_adv_s = '0;
            ky_adv_s = ky_q + KB'(1);
        end else begin
            kx_adv_s = kx_q + KB'(1);
            ky_adv_s = ky_q;
        end
        base_s  = ADDR_BITS'((ADDR_BITS'(ky_q) * ADDR_BITS'(KERNEL_SIZE) + ADDR_BITS'(kx_q))
                             * ADDR_BITS'(IN_CHANNELS));
        first_s = find_ch(sp_q, 0);
        next_s  = find_ch(sp_q, int'(ch_q) + 1);
    end

    // Accumulator plus the weight word returned for the previous cycle's read.
    always_comb begin
        acc_sum_s = acc_q;
        for (int o = 0; o < OUT_CHANNELS; o++) begin
            acc_sum_s[o*SUM_BITS +: SUM_BITS] = acc_q[o*SUM_BITS +: SUM_BITS] +
                                                sext(bram_rdata[o*WEIGHT_BITS +: WEIGHT_BITS]);
        end
    end

    // Next-state logic for the event walk.
    always_comb begin
        state_d     = state_q;
        ex_d        = ex_q;
        ey_d        = ey_q;
        sp_d        = sp_q;
        kx_d        = kx_q;
        ky_d        = ky_q;
        ch_d        = ch_q;
        rvalid_d    = bram_en_q;
        acc_d       = acc_q;
        bram_en_d   = 1'b0;
        bram_addr_d = bram_addr_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_sums_d  = out_sums_q;
        case (state_q)
            S_IDLE: begin
                if (ev_valid && ev_ready_q) begin
                    ex_d    = ev_x;
                    ey_d    = ev_y;
                    sp_d    = ev_spikes;
                    kx_d    = '0;
                    ky_d    = '0;
                    state_d = S_SCAN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SCAN: begin
                acc_d = '0;
                if (sp_q == '0) begin
                    state_d = S_IDLE;
                end else if (inb_s) begin
                    out_x_d     = tx_s[COORD_BITS-1:0];
                    out_y_d     = ty_s[COORD_BITS-1:0];
                    out_last_d  = last_pos_s;
                    ch_d        = first_s[CHB-1:0];
                    bram_en_d   = 1'b1;
                    bram_addr_d = base_s + ADDR_BITS'(first_s[CHB-1:0]);
                    state_d     = S_READ;
                end else if (final_pos_s) begin
                    state_d = S_IDLE;
                end else begin
                    kx_d = kx_adv_s;
                    ky_d = ky_adv_s;
                end
            end
            S_READ: begin
                if (rvalid_q) begin
                    acc_d = acc_sum_s;
                end else begin
                    acc_d = acc_q;
                end
                if (next_s[CHB]) begin
                    ch_d        = next_s[CHB-1:0];
                    bram_en_d   = 1'b1;
                    bram_addr_d = base_s + ADDR_BITS'(next_s[CHB-1:0]);
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                acc_d       = acc_sum_s;
                out_sums_d  = acc_sum_s;
                out_valid_d = 1'b1;
                state_d     = S_EMIT;
            end
            S_EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        state_d = S_IDLE;
                    end else begin
                        kx_d    = kx_adv_s;
                        ky_d    = ky_adv_s;
                        state_d = S_SCAN;
                    end
                end else begin
                    state_d = S_EMIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ev_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ex_q        <= '0;
            ey_q        <= '0;
            sp_q        <= '0;
            kx_q        <= '0;
            ky_q        <= '0;
            ch_q        <= '0;
            rvalid_q    <= 1'b0;
            acc_q       <= '0;
            ev_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            bram_en_q   <= 1'b0;
            bram_addr_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_sums_q  <= '0;
        end else begin
            state_q     <= state_d;
            ex_q        <= ex_d;
            ey_q        <= ey_d;
            sp_q        <= sp_d;
            kx_q        <= kx_d;
            ky_q        <= ky_d;
            ch_q        <= ch_d;
            rvalid_q    <= rvalid_d;
            acc_q       <= acc_d;
            ev_ready_q  <= ev_ready_d;
            busy_q      <= busy_d;
            bram_en_q   <= bram_en_d;
            bram_addr_q <= bram_addr_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_sums_q  <= out_sums_d;
        end
    end

    assign ev_ready  = ev_ready_q;
    assign busy      = busy_q;
    assign bram_en   = bram_en_q;
    assign bram_addr = bram_addr_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_sums  = out_sums_q;

endmodule

// File: tb/tb_conv2d_event_engine.sv
// Self-checking bench: a scatter model predicts beats and BRAM reads for each event,
// a negedge compare process checks the DUT against it, and directed cases pin literal values.
module tb_conv2d_event_engine;

    localparam int IN = 2, OUT = 2, K = 3, W = 6, IW = 8, IH = 8, CB = 8, SB = 8, AB = 5;
    localparam int NW = K * K * IN;

    logic                 clk, rst;
    logic                 ev_valid, ev_ready;
    logic [CB-1:0]        ev_x, ev_y;
    logic [IN-1:0]        ev_spikes;
    logic                 bram_en;
    logic [AB-1:0]        bram_addr;
    logic [OUT*W-1:0]     bram_rdata;
    logic                 out_valid, out_ready, out_last, busy;
    logic [CB-1:0]        out_x, out_y;
    logic [OUT*SB-1:0]    out_sums;

    conv2d_event_engine dut (
        .clk(clk), .rst(rst),
        .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_x(ev_x), .ev_y(ev_y), .ev_spikes(ev_spikes),
        .bram_en(bram_en), .bram_addr(bram_addr), .bram_rdata(bram_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_sums(out_sums), .out_last(out_last),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              x;
        int              y;
        logic [OUT*SB-1:0] sums;
        logic            last;
    } beat_t;

    beat_t         exp_beats[$];
    int            exp_reads[$];
    logic [OUT*W-1:0] wmem [NW];
    int            n_checks = 0, n_fail = 0;
    int            beats_done, reads_done;
    int            obs_fx, obs_fy, obs_lx, obs_ly;
    logic [OUT*SB-1:0] obs_fsums;
    logic          obs_llast;
    beat_t         cmp_e;
    int            cmp_a;

    // One-cycle-latency kernel BRAM.
    always @(posedge clk) begin
        if (bram_en) bram_rdata <= wmem[int'(bram_addr)];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_weights(input int mode);
        for (int a = 0; a < NW; a++) begin
            for (int o = 0; o < OUT; o++) begin
                if (mode == 0) wmem[a][o*W +: W] = W'(1);
                else if (mode == 1) wmem[a][o*W +: W] = 6'h20;
                else wmem[a][o*W +: W] = W'(a * 7 + o * 13 + 40);
            end
        end
    endtask

    // Scatter model: every in-bounds target gets the sum of the active channels' weights.
    task automatic build_model(input int x, input int y, input logic [IN-1:0] sp);
        beat_t b, prev;
        bit    have;
        int    s [OUT];
        int    tx, ty, a;
        logic [OUT*W-1:0] word;
        logic signed [W-1:0] wv;
        have = 0;
        for (int ky = 0; ky < K; ky++) begin
            for (int kx = 0; kx < K; kx++) begin
                tx = x + K / 2 - kx;
                ty = y + K / 2 - ky;
                if (sp != '0 && tx >= 0 && tx < IW && ty >= 0 && ty < IH) begin
                    for (int o = 0; o < OUT; o++) s[o] = 0;
                    for (int ch = 0; ch < IN; ch++) begin
                        if (sp[ch]) begin
                            a = (ky * K + kx) * IN + ch;
                            exp_reads.push_back(a);
                            word = wmem[a];
                            for (int o = 0; o < OUT; o++) begin
                                wv = word[o*W +: W];
                                s[o] += int'(wv);
                            end
                        end
                    end
                    b.x = tx;
                    b.y = ty;
                    b.last = 1'b0;
                    for (int o = 0; o < OUT; o++) b.sums[o*SB +: SB] = SB'(s[o]);
                    if (have) exp_beats.push_back(prev);
                    prev = b;
                    have = 1;
                end
            end
        end
        if (have) begin
            prev.last = 1'b1;
            exp_beats.push_back(prev);
        end
    endtask

    // Compare process: reads and beats against the model on every meaningful cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (bram_en) begin
                check("read_expected", 64'(exp_reads.size() > 0), 64'd1);
                if (exp_reads.size() > 0) begin
                    cmp_a = exp_reads.pop_front();
                    check("read_addr", 64'(bram_addr), 64'(cmp_a));
                    reads_done++;
                end
            end
            if (out_valid) begin
                check("no_read_in_emit", 64'(bram_en), 64'd0);
                check("beat_expected", 64'(exp_beats.size() > 0), 64'd1);
                if (exp_beats.size() > 0) begin
                    cmp_e = exp_beats[0];
                    check("beat_x", 64'(out_x), 64'(cmp_e.x));
                    check("beat_y", 64'(out_y), 64'(cmp_e.y));
                    check("beat_sums", 64'(out_sums), 64'(cmp_e.sums));
                    check("beat_last", 64'(out_last), 64'(cmp_e.last));
                    if (out_ready) begin
                        void'(exp_beats.pop_front());
                        if (beats_done == 0) begin
                            obs_fx = int'(out_x);
                            obs_fy = int'(out_y);
                            obs_fsums = out_sums;
                        end
                        obs_lx = int'(out_x);
                        obs_ly = int'(out_y);
                        obs_llast = out_last;
                        beats_done++;
                    end
                end
            end
        end
    end

    task automatic check_zero(input string name);
        check(name, 64'({ev_ready, busy, bram_en, bram_addr, out_valid, out_last,
                         out_x, out_y, out_sums}), 64'd0);
    endtask

    task automatic start_event(input int x, input int y, input logic [IN-1:0] sp);
        int n;
        n = 0;
        while (!ev_ready && n < 200) begin
            step();
            n++;
        end
        check("accept_wait", 64'(n < 200), 64'd1);
        beats_done = 0;
        reads_done = 0;
        build_model(x, y, sp);
        ev_x = CB'(x);
        ev_y = CB'(y);
        ev_spikes = sp;
        ev_valid = 1'b1;
        step();
        ev_valid = 1'b0;
    endtask

    task automatic finish_event(input int mode, output int cyc);
        int n;
        n = 0;
        while (!ev_ready && n < 2000) begin
            if (mode == 1) out_ready = ((n % 3) != 1);
            step();
            n++;
        end
        out_ready = 1'b1;
        check("done_wait", 64'(n < 2000), 64'd1);
        check("beats_left", 64'(exp_beats.size()), 64'd0);
        check("reads_left", 64'(exp_reads.size()), 64'd0);
        cyc = n;
    endtask

    task automatic run_event(input int x, input int y, input logic [IN-1:0] sp,
                             input int mode, output int cyc);
        start_event(x, y, sp);
        finish_event(mode, cyc);
    endtask

    initial begin
        int cyc, n;
        rst = 1'b1;
        ev_valid = 1'b0;
        ev_x = '0;
        ev_y = '0;
        ev_spikes = '0;
        out_ready = 1'b1;
        beats_done = 0;
        reads_done = 0;
        set_weights(0);
        repeat (3) step();
        check_zero("reset_outputs");
        rst = 1'b0;
        check("ev_ready_at_release", 64'(ev_ready), 64'd0);
        step();
        check("ev_ready_after_reset", 64'(ev_ready), 64'd1);

        // Pin the model with hand-computed values.
        build_model(5, 3, 2'b11);
        check("pin_beats_53", 64'(exp_beats.size()), 64'd9);
        check("pin_reads_53", 64'(exp_reads.size()), 64'd18);
        check("pin_first_xy", 64'({exp_beats[0].x[7:0], exp_beats[0].y[7:0]}), 64'h0604);
        check("pin_first_sums", 64'(exp_beats[0].sums), 64'h0202);
        check("pin_last", 64'({exp_beats[8].x[7:0], exp_beats[8].y[7:0], 7'd0, exp_beats[8].last}), 64'h040201);
        exp_beats.delete();
        exp_reads.delete();
        build_model(0, 0, 2'b01);
        check("pin_reads_00", 64'({exp_reads[0][7:0], exp_reads[1][7:0], exp_reads[2][7:0], exp_reads[3][7:0]}), 64'h00020608);
        check("pin_beat1_00", 64'({exp_beats[1].x[7:0], exp_beats[1].y[7:0]}), 64'h0001);
        exp_beats.delete();
        exp_reads.delete();
        set_weights(1);
        build_model(4, 4, 2'b11);
        check("pin_neg_sums", 64'(exp_beats[0].sums), 64'hC0C0);
        exp_beats.delete();
        exp_reads.delete();
        set_weights(0);

        // Full footprint, both channels.
        run_event(5, 3, 2'b11, 0, cyc);
        check("e53_beats", 64'(beats_done), 64'd9);
        check("e53_reads", 64'(reads_done), 64'd18);
        check("e53_first_xy", 64'({obs_fx[7:0], obs_fy[7:0]}), 64'h0604);
        check("e53_first_sums", 64'(obs_fsums), 64'h0202);
        check("e53_last", 64'({obs_lx[7:0], obs_ly[7:0], 7'd0, obs_llast}), 64'h040201);

        // Corner event, clipped footprint.
        run_event(0, 0, 2'b01, 0, cyc);
        check("e00_beats", 64'(beats_done), 64'd4);
        check("e00_reads", 64'(reads_done), 64'd4);
        check("e00_first_xy", 64'({obs_fx[7:0], obs_fy[7:0]}), 64'h0101);
        check("e00_last_xy", 64'({obs_lx[7:0], obs_ly[7:0]}), 64'h0000);

        // No spikes.
        run_event(4, 4, 2'b00, 0, cyc);
        check("e0_cycles", 64'(cyc), 64'd1);
        check("e0_beats", 64'(beats_done), 64'd0);
        check("e0_reads", 64'(reads_done), 64'd0);

        // Negative weights.
        set_weights(1);
        run_event(4, 4, 2'b11, 0, cyc);
        check("eneg_beats", 64'(beats_done), 64'd9);
        check("eneg_sums", 64'(obs_fsums), 64'hC0C0);

        // Varied weights with backpressure.
        set_weights(2);
        run_event(7, 7, 2'b10, 1, cyc);
        run_event(2, 6, 2'b11, 1, cyc);
        run_event(1, 5, 2'b01, 0, cyc);

        // Entirely out-of-bounds footprint.
        run_event(20, 20, 2'b11, 0, cyc);
        check("oob_cycles", 64'(cyc), 64'd9);
        check("oob_beats", 64'(beats_done), 64'd0);

        // Stall on the first beat.
        set_weights(0);
        out_ready = 1'b0;
        start_event(5, 3, 2'b11);
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        check("stall_wait", 64'(n < 100), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check("stall_hold", 64'({out_valid, out_x, out_y}), 64'h10604);
            step();
        end
        check("stall_reads", 64'(reads_done), 64'd2);
        out_ready = 1'b1;
        finish_event(0, cyc);
        check("stall_beats", 64'(beats_done), 64'd9);

        // Reset during the third position's reads.
        start_event(5, 3, 2'b11);
        n = 0;
        while (!(bram_en && beats_done == 2) && n < 500) begin
            step();
            n++;
        end
        check("midrst_wait", 64'(n < 500), 64'd1);
        rst = 1'b1;
        exp_beats.delete();
        exp_reads.delete();
        step();
        check_zero("midrst_outputs");
        rst = 1'b0;
        run_event(5, 3, 2'b11, 0, cyc);
        check("after_rst_beats", 64'(beats_done), 64'd9);
        check("after_rst_first", 64'({obs_fx[7:0], obs_fy[7:0]}), 64'h0604);
        check("after_rst_last", 64'({obs_lx[7:0], obs_ly[7:0], 7'd0, obs_llast}), 64'h040201);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
